// File: rtl/alu_issue_sched_pkg.sv
// ALU issue scheduler shared types.
// Entry layout and default sizes shared with dispatch and the ALU queue.
package alu_issue_sched_pkg;

  localparam int ALU_DEPTH     = 8;
  localparam int ALU_PRF_W     = 6;
  localparam int ALU_PAYLOAD_W = 64;
  localparam int ALU_CNT_W     = $clog2(ALU_DEPTH + 1);

  typedef logic [ALU_PRF_W-1:0] prf_tag_t;

  typedef struct packed {
    logic                     valid;
    logic [ALU_PAYLOAD_W-1:0] payload;
    prf_tag_t                 src1;
    prf_tag_t                 src2;
    logic                     r1;
    logic                     r2;
  } alu_sched_entry_t;

endpackage

// File: rtl/alu_issue_sched_if.sv
// Dispatch, wakeup and issue bundle of the ALU issue scheduler.
// The master side is dispatch plus the ALU pipes; the slave side is the scheduler.
interface alu_issue_sched_if;
  import alu_issue_sched_pkg::*;

  logic                     flush;
  logic                     wen_0;
  logic                     wen_1;
  logic [ALU_PAYLOAD_W-1:0] din_0;
  logic [ALU_PAYLOAD_W-1:0] din_1;
  prf_tag_t                 src1_0;
  prf_tag_t                 src2_0;
  prf_tag_t                 src1_1;
  prf_tag_t                 src2_1;
  logic                     rdy1_0;
  logic                     rdy2_0;
  logic                     rdy1_1;
  logic                     rdy2_1;
  logic                     wb_valid_0;
  logic                     wb_valid_1;
  prf_tag_t                 wb_tag_0;
  prf_tag_t                 wb_tag_1;
  logic                     iss_valid_0;
  logic                     iss_valid_1;
  logic [ALU_PAYLOAD_W-1:0] iss_payload_0;
  logic [ALU_PAYLOAD_W-1:0] iss_payload_1;
  logic                     iss_ready_0;
  logic                     iss_ready_1;
  logic [ALU_CNT_W-1:0]     count;
  logic                     stall_req;
  logic                     overflow_err;

  modport master (
    output flush, wen_0, wen_1, din_0, din_1,
    output src1_0, src2_0, src1_1, src2_1,
    output rdy1_0, rdy2_0, rdy1_1, rdy2_1,
    output wb_valid_0, wb_valid_1, wb_tag_0, wb_tag_1,
    output iss_ready_0, iss_ready_1,
    input  iss_valid_0, iss_valid_1,
    input  iss_payload_0, iss_payload_1,
    input  count, stall_req, overflow_err
  );

  modport slave (
    input  flush, wen_0, wen_1, din_0, din_1,
    input  src1_0, src2_0, src1_1, src2_1,
    input  rdy1_0, rdy2_0, rdy1_1, rdy2_1,
    input  wb_valid_0, wb_valid_1, wb_tag_0, wb_tag_1,
    input  iss_ready_0, iss_ready_1,
    output iss_valid_0, iss_valid_1,
    output iss_payload_0, iss_payload_1,
    output count, stall_req, overflow_err
  );

endinterface

// File: rtl/pick_two_oldest.sv
// Grants the first and second set request bits counted from index 0.
// Index 0 is the oldest entry, so these are the two oldest requesters.
module pick_two_oldest #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt_0,
  output logic [N-1:0] gnt_1,
  output logic         vld_0,
  output logic         vld_1
);

  logic [N-1:0] rest;

  // x & -x isolates the lowest set bit
  assign gnt_0 = req & (-req);
  assign rest  = req & ~gnt_0;
  assign gnt_1 = rest & (-rest);
  assign vld_0 = |req;
  assign vld_1 = |rest;

endmodule

// File: rtl/alu_issue_sched.sv
// ALU reservation station: collapsing age-ordered queue with tag wakeup
// and dual oldest-ready select feeding two ALU pipes.
module alu_issue_sched
  import alu_issue_sched_pkg::*;
#(
  parameter int DEPTH     = ALU_DEPTH,
  parameter int PRF_W     = ALU_PRF_W,
  parameter int PAYLOAD_W = ALU_PAYLOAD_W,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input logic            clk,
  input logic            rst,
  alu_issue_sched_if.slave io
);

  localparam int IDX_W = $clog2(DEPTH);

  alu_sched_entry_t q  [DEPTH];
  alu_sched_entry_t nq [DEPTH];
  alu_sched_entry_t n0, n1;

  logic [CNT_W-1:0]     cnt, k;
  logic                 ovf;
  logic [DEPTH-1:0]     req, gnt_0, gnt_1, fired;
  logic                 vld_0, vld_1, fire_0, fire_1;
  logic [PAYLOAD_W-1:0] pay_0, pay_1;
  logic [CNT_W:0]       need;
  logic                 space_ok, w0, w1, ovf_set;
  logic [PRF_W-1:0]     wt_0, wt_1;

  function automatic alu_sched_entry_t woken(
    input alu_sched_entry_t e,
    input logic             v0,
    input logic [PRF_W-1:0] t0,
    input logic             v1,
    input logic [PRF_W-1:0] t1
  );
    alu_sched_entry_t r = e;
    r.r1 = e.r1 | (v0 && t0 == e.src1) | (v1 && t1 == e.src1);
    r.r2 = e.r2 | (v0 && t0 == e.src2) | (v1 && t1 == e.src2);
    return r;
  endfunction

  assign wt_0 = io.wb_tag_0;
  assign wt_1 = io.wb_tag_1;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      req[i] = q[i].valid & q[i].r1 & q[i].r2;
    end
  end

  pick_two_oldest #(.N(DEPTH)) u_pick (
    .req   (req),
    .gnt_0 (gnt_0),
    .gnt_1 (gnt_1),
    .vld_0 (vld_0),
    .vld_1 (vld_1)
  );

  assign fire_0 = vld_0 & io.iss_ready_0;
  assign fire_1 = vld_1 & io.iss_ready_1;
  assign fired  = ({DEPTH{fire_0}} & gnt_0)
                | ({DEPTH{fire_1}} & gnt_1);

  always_comb begin
    pay_0 = '0;
    pay_1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (gnt_0[i]) pay_0 |= q[i].payload;
      if (gnt_1[i]) pay_1 |= q[i].payload;
    end
  end

  // Space is judged on the pre-issue count; a lone wen_1 is a protocol error
  assign need     = {1'b0, cnt}
                  + (CNT_W+1)'(io.wen_0)
                  + (CNT_W+1)'(io.wen_1);
  assign space_ok = need <= (CNT_W+1)'(DEPTH);
  assign w0       = io.wen_0 & space_ok;
  assign w1       = io.wen_0 & io.wen_1 & space_ok;
  assign ovf_set  = ((io.wen_0 | io.wen_1) & ~space_ok)
                  | (io.wen_1 & ~io.wen_0);

  always_comb begin
    n0 = woken('{valid:   1'b1,
                 payload: io.din_0,
                 src1:    io.src1_0,
                 src2:    io.src2_0,
                 r1:      io.rdy1_0,
                 r2:      io.rdy2_0},
               io.wb_valid_0, wt_0, io.wb_valid_1, wt_1);
    n1 = woken('{valid:   1'b1,
                 payload: io.din_1,
                 src1:    io.src1_1,
                 src2:    io.src2_1,
                 r1:      io.rdy1_1,
                 r2:      io.rdy2_1},
               io.wb_valid_0, wt_0, io.wb_valid_1, wt_1);
  end

  // Survivors slide toward index 0 in order, then writes land at the tail
  always_comb begin
    for (int i = 0; i < DEPTH; i++) nq[i] = '0;
    k = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].valid && !fired[i]) begin
        nq[k[IDX_W-1:0]] = woken(q[i], io.wb_valid_0, wt_0,
                                 io.wb_valid_1, wt_1);
        k = k + CNT_W'(1);
      end
    end
    if (w0 && k < CNT_W'(DEPTH)) begin
      nq[k[IDX_W-1:0]] = n0;
      k = k + CNT_W'(1);
    end
    if (w1 && k < CNT_W'(DEPTH)) begin
      nq[k[IDX_W-1:0]] = n1;
      k = k + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= '{default: '0};
      cnt <= '0;
      ovf <= 1'b0;
    end else if (io.flush) begin
      q   <= '{default: '0};
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      q   <= nq;
      cnt <= k;
      ovf <= ovf | ovf_set;
    end
  end

  assign io.iss_valid_0   = vld_0;
  assign io.iss_valid_1   = vld_1;
  assign io.iss_payload_0 = pay_0;
  assign io.iss_payload_1 = pay_1;
  assign io.count         = cnt;
  assign io.stall_req     = (CNT_W'(DEPTH) - cnt) < CNT_W'(2);
  assign io.overflow_err  = ovf;

endmodule

// File: tb/tb_alu_issue_sched.sv
// Bench for alu_issue_sched: directed scenarios plus random traffic,
// all checked against a queue-based age-ordered reference model.
module tb_alu_issue_sched;
  import alu_issue_sched_pkg::*;

  localparam int D = ALU_DEPTH;

  localparam logic [63:0] PA = 64'hAAAA_0000_0000_0001;
  localparam logic [63:0] PB = 64'hBBBB_0000_0000_0002;
  localparam logic [63:0] PC = 64'hCCCC_0000_0000_0003;
  localparam logic [63:0] PD = 64'hDDDD_0000_0000_0004;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_issue_sched_if bus ();

  alu_issue_sched dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  typedef struct {
    logic [63:0] pl;
    logic [5:0]  s1;
    logic [5:0]  s2;
    logic        r1;
    logic        r2;
  } mop_t;

  mop_t mq[$];
  logic movf = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic woke(logic [5:0] t);
    return (bus.wb_valid_0 && bus.wb_tag_0 == t)
        || (bus.wb_valid_1 && bus.wb_tag_1 == t);
  endfunction

  task automatic check_outputs();
    int p0 = -1;
    int p1 = -1;
    foreach (mq[i]) begin
      if (mq[i].r1 && mq[i].r2) begin
        if (p0 < 0) p0 = i;
        else if (p1 < 0) p1 = i;
      end
    end
    check_eq("iss_valid_0", 64'(bus.iss_valid_0), 64'(p0 >= 0));
    check_eq("iss_valid_1", 64'(bus.iss_valid_1), 64'(p1 >= 0));
    if (p0 >= 0) check_eq("iss_payload_0", bus.iss_payload_0, mq[p0].pl);
    if (p1 >= 0) check_eq("iss_payload_1", bus.iss_payload_1, mq[p1].pl);
    check_eq("count", 64'(bus.count), 64'(mq.size()));
    check_eq("stall_req", 64'(bus.stall_req), 64'((D - mq.size()) < 2));
    check_eq("overflow_err", 64'(bus.overflow_err), 64'(movf));
  endtask

  task automatic model_step();
    int   p0 = -1;
    int   p1 = -1;
    int   pre;
    int   n;
    mop_t e;
    pre = mq.size();
    if (bus.flush) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      foreach (mq[i]) begin
        if (mq[i].r1 && mq[i].r2) begin
          if (p0 < 0) p0 = i;
          else if (p1 < 0) p1 = i;
        end
      end
      if (p1 >= 0 && bus.iss_ready_1) mq.delete(p1);
      if (p0 >= 0 && bus.iss_ready_0) mq.delete(p0);
      foreach (mq[i]) begin
        mq[i].r1 = mq[i].r1 | woke(mq[i].s1);
        mq[i].r2 = mq[i].r2 | woke(mq[i].s2);
      end
      if (bus.wen_1 && !bus.wen_0) begin
        movf = 1'b1;
      end else if (bus.wen_0) begin
        n = bus.wen_1 ? 2 : 1;
        if (pre + n > D) begin
          movf = 1'b1;
        end else begin
          e.pl = bus.din_0;
          e.s1 = bus.src1_0;
          e.s2 = bus.src2_0;
          e.r1 = bus.rdy1_0 | woke(bus.src1_0);
          e.r2 = bus.rdy2_0 | woke(bus.src2_0);
          mq.push_back(e);
          if (bus.wen_1) begin
            e.pl = bus.din_1;
            e.s1 = bus.src1_1;
            e.s2 = bus.src2_1;
            e.r1 = bus.rdy1_1 | woke(bus.src1_1);
            e.r2 = bus.rdy2_1 | woke(bus.src2_1);
            mq.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    bus.flush       = 1'b0;
    bus.wen_0       = 1'b0;
    bus.wen_1       = 1'b0;
    bus.din_0       = '0;
    bus.din_1       = '0;
    bus.src1_0      = '0;
    bus.src2_0      = '0;
    bus.src1_1      = '0;
    bus.src2_1      = '0;
    bus.rdy1_0      = 1'b0;
    bus.rdy2_0      = 1'b0;
    bus.rdy1_1      = 1'b0;
    bus.rdy2_1      = 1'b0;
    bus.wb_valid_0  = 1'b0;
    bus.wb_valid_1  = 1'b0;
    bus.wb_tag_0    = '0;
    bus.wb_tag_1    = '0;
    bus.iss_ready_0 = 1'b0;
    bus.iss_ready_1 = 1'b0;
  endtask

  task automatic put(int slot, logic [63:0] pl, logic [5:0] s1,
                     logic [5:0] s2, logic r1, logic r2);
    if (slot == 0) begin
      bus.wen_0 = 1'b1; bus.din_0 = pl;
      bus.src1_0 = s1;  bus.src2_0 = s2;
      bus.rdy1_0 = r1;  bus.rdy2_0 = r2;
    end else begin
      bus.wen_1 = 1'b1; bus.din_1 = pl;
      bus.src1_1 = s1;  bus.src2_1 = s2;
      bus.rdy1_1 = r1;  bus.rdy2_1 = r2;
    end
  endtask

  task automatic rand_inputs();
    bus.flush  = ($urandom_range(0, 63) == 0);
    bus.wen_0  = ($urandom_range(0, 2) != 0);
    bus.wen_1  = bus.wen_0 && ($urandom_range(0, 1) == 1);
    if ((D - mq.size()) < 2 && $urandom_range(0, 7) != 0) begin
      bus.wen_0 = 1'b0;
      bus.wen_1 = 1'b0;
    end
    if ($urandom_range(0, 99) == 0) begin
      bus.wen_0 = 1'b0;
      bus.wen_1 = 1'b1;
    end
    bus.din_0       = {$urandom(), $urandom()};
    bus.din_1       = {$urandom(), $urandom()};
    bus.src1_0      = 6'($urandom_range(0, 7));
    bus.src2_0      = 6'($urandom_range(0, 7));
    bus.src1_1      = 6'($urandom_range(0, 7));
    bus.src2_1      = 6'($urandom_range(0, 7));
    bus.rdy1_0      = ($urandom_range(0, 2) == 0);
    bus.rdy2_0      = ($urandom_range(0, 2) == 0);
    bus.rdy1_1      = ($urandom_range(0, 2) == 0);
    bus.rdy2_1      = ($urandom_range(0, 2) == 0);
    bus.wb_valid_0  = ($urandom_range(0, 1) == 1);
    bus.wb_valid_1  = ($urandom_range(0, 1) == 1);
    bus.wb_tag_0    = 6'($urandom_range(0, 7));
    bus.wb_tag_1    = 6'($urandom_range(0, 7));
    bus.iss_ready_0 = ($urandom_range(0, 3) != 0);
    bus.iss_ready_1 = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      rand_inputs();
    end
    #1 check_outputs();
    @(negedge clk);
    idle();
    rst = 1'b1;
    check_outputs();

    // dual write then dual issue
    put(0, PA, 6'd1, 6'd2, 1'b1, 1'b1);
    put(1, PB, 6'd3, 6'd4, 1'b1, 1'b1);
    bus.iss_ready_0 = 1'b1;
    bus.iss_ready_1 = 1'b1;
    cycle();
    check_eq("t2_pay0", bus.iss_payload_0, PA);
    check_eq("t2_pay1", bus.iss_payload_1, PB);
    idle();
    bus.iss_ready_0 = 1'b1;
    bus.iss_ready_1 = 1'b1;
    cycle();
    check_eq("t2_count", 64'(bus.count), 64'd0);

    // wakeup one cycle after write, then in the write cycle
    idle();
    put(0, PC, 6'd5, 6'd9, 1'b0, 1'b1);
    cycle();
    check_eq("t3_wait", 64'(bus.iss_valid_0), 64'd0);
    idle();
    bus.wb_valid_0 = 1'b1;
    bus.wb_tag_0   = 6'd5;
    cycle();
    check_eq("t3_woke_v", 64'(bus.iss_valid_0), 64'd1);
    check_eq("t3_woke_p", bus.iss_payload_0, PC);
    idle();
    bus.iss_ready_0 = 1'b1;
    cycle();
    idle();
    put(0, PD, 6'd5, 6'd9, 1'b0, 1'b1);
    bus.wb_valid_0 = 1'b1;
    bus.wb_tag_0   = 6'd5;
    cycle();
    check_eq("t3_same_v", 64'(bus.iss_valid_0), 64'd1);
    check_eq("t3_same_p", bus.iss_payload_0, PD);
    idle();
    bus.iss_ready_0 = 1'b1;
    cycle();

    // slot 1 accepted, slot 0 refused
    idle();
    put(0, PA, 6'd1, 6'd2, 1'b1, 1'b1);
    put(1, PB, 6'd3, 6'd4, 1'b1, 1'b1);
    cycle();
    idle();
    bus.iss_ready_1 = 1'b1;
    cycle();
    check_eq("t4_count", 64'(bus.count), 64'd1);
    check_eq("t4_pay0", bus.iss_payload_0, PA);
    check_eq("t4_v1", 64'(bus.iss_valid_1), 64'd0);
    idle();
    bus.iss_ready_0 = 1'b1;
    cycle();

    // fill to DEPTH, then overflow
    for (int c = 0; c < 4; c++) begin
      idle();
      put(0, 64'(100 + 2 * c), 6'd60, 6'd61, 1'b0, 1'b0);
      put(1, 64'(101 + 2 * c), 6'd60, 6'd61, 1'b0, 1'b0);
      cycle();
      check_eq("t5_count", 64'(bus.count), 64'(2 * (c + 1)));
    end
    check_eq("t5_stall", 64'(bus.stall_req), 64'd1);
    idle();
    put(0, PC, 6'd60, 6'd61, 1'b0, 1'b0);
    put(1, PD, 6'd60, 6'd61, 1'b0, 1'b0);
    cycle();
    check_eq("t5_ovf_count", 64'(bus.count), 64'd8);
    check_eq("t5_ovf", 64'(bus.overflow_err), 64'd1);

    // drain to six entries, then flush with write and issue pending
    idle();
    bus.wb_valid_0 = 1'b1;
    bus.wb_tag_0   = 6'd60;
    bus.wb_valid_1 = 1'b1;
    bus.wb_tag_1   = 6'd61;
    cycle();
    idle();
    bus.iss_ready_0 = 1'b1;
    bus.iss_ready_1 = 1'b1;
    cycle();
    check_eq("t6_pre_count", 64'(bus.count), 64'd6);
    idle();
    put(0, PA, 6'd1, 6'd2, 1'b1, 1'b1);
    put(1, PB, 6'd3, 6'd4, 1'b1, 1'b1);
    bus.iss_ready_0 = 1'b1;
    bus.iss_ready_1 = 1'b1;
    bus.flush = 1'b1;
    cycle();
    check_eq("t6_count", 64'(bus.count), 64'd0);
    check_eq("t6_v0", 64'(bus.iss_valid_0), 64'd0);
    check_eq("t6_ovf", 64'(bus.overflow_err), 64'd0);
    idle();
    cycle();

    // random traffic with occasional asynchronous reset
    repeat (3000) begin
      rand_inputs();
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b0;
        mq.delete();
        movf = 1'b0;
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b1;
        check_outputs();
      end else begin
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
